// File: rtl/serial_pkg.sv
// -----------------------------------------------------------------------------
// serial_pkg
// Shared types and constants for the serial transmit scheduler slice.
//   sched_state_t : scheduler FSM state encoding
//   SER_DATA_W    : payload width of one serial_tx frame
// -----------------------------------------------------------------------------
package serial_pkg;

   localparam int SER_DATA_W = 4;

   typedef enum logic [1:0] {
      S_ARB    = 2'd0,
      S_ISSUE  = 2'd1,
      S_LAUNCH = 2'd2,
      S_DRAIN  = 2'd3
   } sched_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick. The search starts at ptr+1 (mod N)
// and wraps, so the requester at ptr itself has the lowest priority.
// The pointer register is owned by the caller.
// Ports:
//   req  in  N   request vector
//   ptr  in  IW  index of the most recently granted requester
//   gnt  out N   one-hot grant (zero when no request)
//   idx  out IW  index of the granted requester (0 when none)
//   any  out 1   at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   // One extra bit so ptr + offset never overflows before the modulo fold.
   logic [IW:0]   sum;
   logic [IW-1:0] cand;
   logic          found;

   always_comb begin
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      sum   = '0;
      cand  = '0;
      for (int i = 1; i <= N; i++) begin
         sum = {1'b0, ptr} + (IW+1)'(i);
         if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
         end
         cand = sum[IW-1:0];
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt[cand] = 1'b1;
            idx       = cand;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// serial_tx_scheduler
// Shares one serial_tx transmitter between NREQ requesters, one DATA_W-bit
// frame per grant, with round-robin arbitration.
//
// Handshake semantics (requester side): a requester raises req_valid[i] with
// its payload on req_data slice i and keeps both until it sees req_ready[i]
// high for one cycle; the payload is captured on that same edge, so the
// requester may drop or change req_valid/req_data immediately afterwards.
// Transmitter side: tx_valid and tx_ready are high together for exactly one
// cycle (S_ISSUE); serial_tx accepts on that cycle and signals the frame on
// the line by raising tx_busy. tx_data is held from accept to S_DRAIN exit.
//
// Ports:
//   clk          in   1             system clock, rising edge
//   rst          in   1             asynchronous active-high reset
//   req_valid    in   NREQ          requester i has a frame pending
//   req_data     in   NREQ*DATA_W   payload, slice i = req_data[i*DATA_W +: DATA_W]
//   req_ready    out  NREQ          one-hot 1-cycle accept pulse
//   tx_ready     out  1             to serial_tx ready
//   tx_valid     out  1             to serial_tx valid_in
//   tx_data      out  DATA_W        to serial_tx data_in
//   tx_busy      in   1             from serial_tx busy_out
//   owner        out  clog2(NREQ)   current/last granted requester
//   active       out  1             high from S_ISSUE through S_DRAIN
//   timeout_err  out  1             sticky launch-timeout flag
// -----------------------------------------------------------------------------
module serial_tx_scheduler
   import serial_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int DATA_W   = SER_DATA_W,
   parameter int START_TO = 15,
   localparam int IW      = (NREQ > 1) ? $clog2(NREQ) : 1,
   localparam int TW      = (START_TO > 0) ? $clog2(START_TO + 1) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid,
   input  logic [NREQ*DATA_W-1:0] req_data,
   output logic [NREQ-1:0]        req_ready,
   output logic                   tx_ready,
   output logic                   tx_valid,
   output logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_busy,
   output logic [IW-1:0]          owner,
   output logic                   active,
   output logic                   timeout_err
);

   localparam logic [TW-1:0] TIMER_MAX = '1;
   // Timer value seen during the last permitted S_LAUNCH cycle.
   localparam logic [TW-1:0] TO_LAST   = TW'(START_TO - 1);

   sched_state_t          state_q, state_d;
   logic [IW-1:0]         ptr_q, ptr_d;
   logic [IW-1:0]         owner_q, owner_d;
   logic [DATA_W-1:0]     tx_data_q, tx_data_d;
   logic [NREQ-1:0]       req_ready_q, req_ready_d;
   logic [TW-1:0]         timer_q, timer_d;
   logic                  timeout_err_q, timeout_err_d;

   logic [NREQ-1:0]       arb_gnt;
   logic [IW-1:0]         arb_idx;
   logic                  arb_any;
   logic [DATA_W-1:0]     arb_data;

   rr_arbiter #(
      .N  (NREQ),
      .IW (IW)
   ) u_arb (
      .req (req_valid),
      .ptr (ptr_q),
      .gnt (arb_gnt),
      .idx (arb_idx),
      .any (arb_any)
   );

   // Payload of the winning requester; the grant is one-hot so at most one
   // slice is selected.
   always_comb begin
      arb_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (arb_gnt[i]) begin
            arb_data = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      ptr_d         = ptr_q;
      owner_d       = owner_q;
      tx_data_d     = tx_data_q;
      req_ready_d   = '0;
      timer_d       = timer_q;
      timeout_err_d = timeout_err_q;

      unique case (state_q)
         S_ARB: begin
            // A busy transmitter here is a protocol error: never grant into it.
            if (arb_any && !tx_busy) begin
               req_ready_d = arb_gnt;
               tx_data_d   = arb_data;
               owner_d     = arb_idx;
               ptr_d       = arb_idx;
               state_d     = S_ISSUE;
            end
         end

         S_ISSUE: begin
            timer_d = '0;
            state_d = S_LAUNCH;
         end

         S_LAUNCH: begin
            if (tx_busy) begin
               state_d = S_DRAIN;
            end else if (timer_q >= TO_LAST) begin
               // Transmitter never started: drop the frame and flag it.
               timeout_err_d = 1'b1;
               state_d       = S_ARB;
            end else begin
               timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + 1'b1;
            end
         end

         S_DRAIN: begin
            if (!tx_busy) begin
               state_d = S_ARB;
            end
         end

         default: begin
            state_d = S_ARB;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_ARB;
         ptr_q         <= IW'(NREQ - 1);
         owner_q       <= '0;
         tx_data_q     <= '0;
         req_ready_q   <= '0;
         timer_q       <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ptr_q         <= ptr_d;
         owner_q       <= owner_d;
         tx_data_q     <= tx_data_d;
         req_ready_q   <= req_ready_d;
         timer_q       <= timer_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign tx_valid    = (state_q == S_ISSUE);
   assign tx_ready    = (state_q == S_ISSUE);
   assign tx_data     = tx_data_q;
   assign owner       = owner_q;
   assign active      = (state_q != S_ARB);
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_serial_tx_scheduler
// Directed bench for serial_tx_scheduler (NREQ=4) with a small behavioural
// serial transmitter: start bit, DATA_W bits LSB first, stop bit, one bit per
// clock, busy for the whole frame. The transmitter shifts from the live
// tx_data so any change during a frame shows on the line.
// -----------------------------------------------------------------------------
module tb_serial_tx_scheduler;

   localparam int NREQ     = 4;
   localparam int DATA_W   = 4;
   localparam int START_TO = 15;

   // ---------------- clock / reset ----------------
   logic                   clk = 1'b0;
   logic                   rst;
   always #5 clk = ~clk;

   logic [NREQ-1:0]        req_valid;
   logic [NREQ*DATA_W-1:0] req_data;
   logic [NREQ-1:0]        req_ready;
   logic                   tx_ready;
   logic                   tx_valid;
   logic [DATA_W-1:0]      tx_data;
   logic                   tx_busy;
   logic [1:0]             owner;
   logic                   active;
   logic                   timeout_err;

   serial_tx_scheduler #(
      .NREQ     (NREQ),
      .DATA_W   (DATA_W),
      .START_TO (START_TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_ready    (tx_ready),
      .tx_valid    (tx_valid),
      .tx_data     (tx_data),
      .tx_busy     (tx_busy),
      .owner       (owner),
      .active      (active),
      .timeout_err (timeout_err)
   );

   // ---------------- transmitter model ----------------
   logic       m_busy;
   logic [2:0] m_idx;
   logic       stub_mode;
   logic       line;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0;
         m_idx  <= 3'd0;
      end else if (m_busy) begin
         if (m_idx == 3'd5) m_busy <= 1'b0;
         m_idx <= m_idx + 3'd1;
      end else if (!stub_mode && tx_valid && tx_ready) begin
         m_busy <= 1'b1;
         m_idx  <= 3'd0;
      end
   end

   assign tx_busy = m_busy;

   always_comb begin
      line = 1'b1;
      if (m_busy) begin
         if (m_idx == 3'd0)      line = 1'b0;
         else if (m_idx == 3'd5) line = 1'b1;
         else                    line = tx_data[m_idx - 3'd1];
      end
   end

   // ---------------- scoreboard ----------------
   logic [DATA_W-1:0] exp_q[$];
   int                gnt_q[$];
   int                n_checks = 0;
   int                n_errors = 0;
   int                gnt_cnt  = 0;
   int                frame_cnt = 0;
   logic [DATA_W-1:0] cur_data = '0;
   logic [5:0]        bits = '0;
   logic [5:0]        last_bits = '0;
   logic              chk_drop = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic expect_grant(input int idx, input logic [DATA_W-1:0] data);
      gnt_q.push_back(idx);
      exp_q.push_back(data);
   endtask

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (chk_drop) begin
            check("tx_valid_one_cycle", {31'd0, tx_valid}, 32'd0);
            chk_drop = 1'b0;
         end
         if (req_ready != '0) begin
            check("req_ready_onehot", $countones(req_ready), 1);
            if (gnt_q.size() == 0) begin
               check("unexpected_grant", {28'd0, req_ready}, 32'd0);
            end else begin
               int g;
               g = gnt_q.pop_front();
               cur_data = exp_q.pop_front();
               check("grant", {28'd0, req_ready}, 32'd1 << g);
               check("owner", {30'd0, owner}, g);
               check("tx_data_accept", {28'd0, tx_data}, {28'd0, cur_data});
            end
            check("tx_valid_issue", {30'd0, tx_valid, tx_ready}, 32'd3);
            chk_drop = 1'b1;
            gnt_cnt++;
         end else if (active) begin
            check("tx_data_stable", {28'd0, tx_data}, {28'd0, cur_data});
         end
         if (tx_busy) begin
            bits[m_idx] = line;
            if (m_idx == 3'd5) begin
               check("frame_start", {31'd0, bits[0]}, 32'd0);
               check("frame_stop", {31'd0, bits[5]}, 32'd1);
               check("frame_data", {28'd0, bits[4:1]}, {28'd0, cur_data});
               last_bits = bits;
               frame_cnt++;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      gnt_q.delete();
      exp_q.delete();
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_ready", {28'd0, req_ready}, 32'd0);
      check("rst_tx_valid", {30'd0, tx_valid, tx_ready}, 32'd0);
      check("rst_active", {31'd0, active}, 32'd0);
      check("rst_owner", {30'd0, owner}, 32'd0);
      check("rst_tx_data", {28'd0, tx_data}, 32'd0);
      check("rst_timeout", {31'd0, timeout_err}, 32'd0);
      rst       = 1'b0;
      gnt_cnt   = 0;
      frame_cnt = 0;
      chk_drop  = 1'b0;
   endtask

   task automatic wait_grants(input int target, input string tag);
      int n = 0;
      while (gnt_cnt < target && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      check(tag, gnt_cnt, target);
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while ((active || tx_busy) && n < 400) begin
         @(negedge clk); #1;
         n++;
      end
      check(tag, {30'd0, active, tx_busy}, 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      int f0;
      rst       = 1'b1;
      req_valid = '0;
      req_data  = '0;
      stub_mode = 1'b0;

      // 1: single requester, line pattern for 4'hA
      do_reset();
      req_data = 16'h00A0;
      expect_grant(1, 4'hA);
      req_valid = 4'b0010;
      wait_grants(1, "t1_grant_wait");
      req_valid = '0;
      wait_idle("t1_idle");
      check("t1_line", {26'd0, last_bits}, 32'h34);
      check("t1_frames", frame_cnt, 1);
      check("t1_owner", {30'd0, owner}, 32'd1);

      // 2: full contention, strict rotation
      do_reset();
      req_data = 16'h4321;
      expect_grant(0, 4'h1);
      expect_grant(1, 4'h2);
      expect_grant(2, 4'h3);
      expect_grant(3, 4'h4);
      expect_grant(0, 4'h1);
      req_valid = 4'b1111;
      wait_grants(5, "t2_grant_wait");
      req_valid = '0;
      wait_idle("t2_idle");
      check("t2_frames", frame_cnt, 5);

      // 3: sparse requests, pointer wraps 3 -> 0
      do_reset();
      req_data = 16'h0C05;
      expect_grant(0, 4'h5);
      expect_grant(2, 4'hC);
      expect_grant(0, 4'h5);
      expect_grant(2, 4'hC);
      req_valid = 4'b0101;
      wait_grants(4, "t3_grant_wait");
      req_valid = '0;
      wait_idle("t3_idle");
      check("t3_frames", frame_cnt, 4);
      check("t3_owner", {30'd0, owner}, 32'd2);

      // 4: payload churn after accept must not reach the line
      f0 = frame_cnt;
      req_data = 16'h0500;
      expect_grant(2, 4'h5);
      req_valid = 4'b0100;
      wait_grants(5, "t4_grant_wait");
      req_valid = '0;
      for (int i = 0; i < 12; i++) begin
         req_data = {4'($urandom_range(0, 15)), 4'hA,
                     4'($urandom_range(0, 15)), 4'($urandom_range(0, 15))};
         @(negedge clk); #1;
      end
      wait_idle("t4_idle");
      check("t4_frames", frame_cnt - f0, 1);
      check("t4_hold", {28'd0, tx_data}, 32'h5);

      // 5: transmitter never starts -> timeout after START_TO launch cycles
      do_reset();
      stub_mode = 1'b1;
      req_data  = 16'h0007;
      expect_grant(0, 4'h7);
      req_valid = 4'b0001;
      wait_grants(1, "t5_grant_wait");
      req_valid = '0;
      n = 0;
      while (!timeout_err && n < 40) begin
         @(negedge clk); #1;
         n++;
      end
      check("t5_timeout_cycles", n, START_TO + 1);
      check("t5_back_to_arb", {31'd0, active}, 32'd0);
      stub_mode = 1'b0;
      req_data  = 16'h9000;
      expect_grant(3, 4'h9);
      req_valid = 4'b1000;
      wait_grants(2, "t5_regrant_wait");
      req_valid = '0;
      wait_idle("t5_idle");
      check("t5_frames", frame_cnt, 1);
      check("t5_sticky", {31'd0, timeout_err}, 32'd1);

      // 6: asynchronous reset during S_DRAIN
      do_reset();
      req_data = 16'h00E0;
      expect_grant(1, 4'hE);
      req_valid = 4'b0010;
      wait_grants(1, "t6_grant_wait");
      req_valid = '0;
      n = 0;
      while (!(tx_busy && active) && n < 20) begin
         @(negedge clk); #1;
         n++;
      end
      check("t6_in_drain", {30'd0, tx_busy, active}, 32'd3);
      @(negedge clk); #2;
      rst = 1'b1;
      #1;
      check("t6_async_active", {31'd0, active}, 32'd0);
      check("t6_async_tx", {30'd0, tx_valid, tx_ready}, 32'd0);
      check("t6_async_data", {28'd0, tx_data}, 32'd0);
      check("t6_async_owner", {30'd0, owner}, 32'd0);
      check("t6_async_busy", {31'd0, tx_busy}, 32'd0);
      gnt_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst       = 1'b0;
      gnt_cnt   = 0;
      frame_cnt = 0;
      chk_drop  = 1'b0;
      req_data  = 16'h4321;
      expect_grant(0, 4'h1);
      req_valid = 4'b1111;
      wait_grants(1, "t6_grant_after_rst");
      req_valid = '0;
      wait_idle("t6_idle");
      check("t6_frames", frame_cnt, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
